// File: rtl/mult_eval_pkg.sv
// Shared types and helpers for the approximate-multiplier evaluation blocks.
// Holds the run-control state encoding, operand/product/difference widths,
// and the absolute-difference helper used by the error pipeline.
package mult_eval_pkg;

  localparam int OP_W   = 4;  // multiplier operand width
  localparam int PROD_W = 8;  // exact product width (15*15 = 225 fits)
  localparam int DIFF_W = 9;  // signed p - exact, range [-225, 255]

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Magnitude of a signed product difference. The difference range
  // [-225, 255] always fits in PROD_W bits, so the truncation is lossless.
  function automatic logic [PROD_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? PROD_W'(-d) : PROD_W'(d);
  endfunction

endpackage

// File: rtl/mult4_err_monitor_err_accum.sv
// Purpose: per-run error statistics accumulator (counts, saturating sum, wrapping signed sum, max).
// Latency: one cycle from a valid input to updated outputs.
// Backpressure: none; accepts one entry every cycle that valid is high.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   clear         synchronous clear of all statistics (start of a new run)
//   valid         diff/abs_val carry a sample to accumulate this cycle
//   diff          signed product difference (p - exact)
//   abs_val       |diff|
//   sample_cnt    number of samples accumulated
//   err_cnt       number of samples with a non-zero difference
//   sum_abs_err   saturating sum of |diff|
//   sum_err       wrapping two's-complement sum of diff
//   max_abs_err   largest |diff| seen
module err_accum
  import mult_eval_pkg::*;
#(
  parameter int SUM_W = 16,
  parameter int CNT_W = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     valid,
  input  logic signed [DIFF_W-1:0] diff,
  input  logic [PROD_W-1:0]        abs_val,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [SUM_W-1:0]         sum_abs_err,
  output logic [SUM_W:0]           sum_err,
  output logic [PROD_W-1:0]        max_abs_err
);

  // One guard bit above the wider of the accumulator and the addend so the
  // carry out of the add is visible for the saturation decision.
  localparam int EXT_W = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;
  localparam logic [EXT_W-1:0] SAT_MAX = EXT_W'({SUM_W{1'b1}});

  logic [EXT_W-1:0]        sum_ext;
  logic signed [SUM_W:0]   diff_ext;

  assign sum_ext  = EXT_W'(sum_abs_err) + EXT_W'(abs_val);
  // Sign extension of the 9-bit difference up to the signed-sum width.
  assign diff_ext = (SUM_W+1)'(diff);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      sum_err     <= '0;
      max_abs_err <= '0;
    end else if (valid) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (abs_val != '0) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      sum_abs_err <= (sum_ext > SAT_MAX) ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      // Deliberately wraps: the signed sum is a bias indicator, not a bound.
      sum_err <= sum_err + diff_ext;
      if (abs_val > max_abs_err) begin
        max_abs_err <= abs_val;
      end
    end
  end

endmodule

// File: rtl/mult4_err_monitor.sv
// Purpose: evaluates a 4x4 approximate multiplier stream against the exact product over fixed-length runs.
// Latency: 3 cycles from a transfer to its effect on the statistics; done 3 cycles after the last transfer.
// Backpressure: in_ready is high only in RUN until N_SAMPLES transfers have been taken; never depends on in_valid.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse; begins a run from IDLE or DONE, clears statistics
//   in_valid/in_ready  sample handshake; transfer when both high
//   in_a, in_b      operands fed to the multiplier under evaluation
//   in_p            product reported by the multiplier under evaluation
//   busy            run in progress (RUN or DRAIN)
//   done            run complete, statistics stable (DONE)
//   sample_cnt, err_cnt, sum_abs_err, sum_err, max_abs_err   run statistics
module mult4_err_monitor
  import mult_eval_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int SUM_W     = 16,
  parameter int CNT_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_p,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_abs_err,
  output logic [SUM_W:0]    sum_err,
  output logic [PROD_W-1:0] max_abs_err
);

  state_t             state;
  logic [CNT_W-1:0]   accepted;
  logic               xfer;
  logic               last_xfer;
  logic               start_run;

  // Stage 1: captured sample plus combinational exact product.
  logic               s1_vld;
  logic [OP_W-1:0]    s1_a;
  logic [OP_W-1:0]    s1_b;
  logic [PROD_W-1:0]  s1_p;
  logic [PROD_W-1:0]  s1_exact;
  logic signed [DIFF_W-1:0] s1_diff;

  // Stage 2: registered difference and its magnitude.
  logic               s2_vld;
  logic signed [DIFF_W-1:0] s2_diff;
  logic [PROD_W-1:0]  s2_abs;

  assign in_ready  = (state == RUN) && (accepted < CNT_W'(N_SAMPLES));
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (accepted == CNT_W'(N_SAMPLES - 1));
  // start only has an effect from IDLE or DONE; a pulse mid-run is dropped.
  assign start_run = start && ((state == IDLE) || (state == DONE));

  assign s1_exact = PROD_W'(s1_a) * PROD_W'(s1_b);
  assign s1_diff  = $signed({1'b0, s1_p}) - $signed({1'b0, s1_exact});

  // Run control. busy/done are registered alongside the state so they
  // change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      accepted <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            accepted <= '0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            accepted <= accepted + CNT_W'(1);
          end
          if (last_xfer) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last sample is in S1 on the first DRAIN cycle and in S2 on
          // the second; once both are empty the accumulator has absorbed it.
          if (!s1_vld && !s2_vld) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state    <= RUN;
            accepted <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline valid bits: advance unconditionally, flushed on reset and on
  // the start of a new run.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= xfer;
      s2_vld <= s1_vld;
    end
  end

  // Pipeline data: only meaningful alongside the matching valid bit, so no
  // reset is needed here.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_a <= in_a;
      s1_b <= in_b;
      s1_p <= in_p;
    end
    if (s1_vld) begin
      s2_diff <= s1_diff;
      s2_abs  <= abs_diff(s1_diff);
    end
  end

  err_accum #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_err_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_run),
    .valid       (s2_vld),
    .diff        (s2_diff),
    .abs_val     (s2_abs),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .sum_err     (sum_err),
    .max_abs_err (max_abs_err)
  );

endmodule

// File: tb/tb_mult4_err_monitor.sv
// Bench for mult4_err_monitor: table of full-run patterns, randomized run
// against a reference model, plus reset-abort and saturation sequences.
module tb_mult4_err_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid;
  logic [3:0] in_a, in_b;
  logic [7:0] in_p;
  logic       in_ready, busy, done;
  logic [16:0] sample_cnt, err_cnt;
  logic [15:0] sum_abs_err;
  logic [16:0] sum_err;
  logic [7:0]  max_abs_err;

  // Second instance: short run, narrow accumulator for saturation/wrap.
  logic       s_start, s_valid;
  logic [3:0] s_a, s_b;
  logic [7:0] s_p;
  logic       s_ready, s_busy, s_done;
  logic [2:0] s_sample_cnt, s_err_cnt;
  logic [7:0] s_sum_abs_err;
  logic [8:0] s_sum_err;
  logic [7:0] s_max_abs_err;

  always #5 clk = ~clk;

  mult4_err_monitor #(.N_SAMPLES(256), .SUM_W(16), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
    .sum_err(sum_err), .max_abs_err(max_abs_err)
  );

  mult4_err_monitor #(.N_SAMPLES(4), .SUM_W(8), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_p(s_p), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .sum_abs_err(s_sum_abs_err),
    .sum_err(s_sum_err), .max_abs_err(s_max_abs_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample set for one run (index = a*16 + b).
  logic [3:0] sa[256];
  logic [3:0] sb[256];
  logic [7:0] sp[256];

  task automatic build(input int mode);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int i, e, p;
        i = a * 16 + b;
        e = a * b;
        p = e;
        case (mode)
          1: if (a == 3) p = e + 1;
          2: if (e >= 2) p = e - 2;
          3: p = int'($urandom_range(255));
          4: if (a == 0 && b == 0) p = 255;
          default: p = e;
        endcase
        sa[i] = 4'(a);
        sb[i] = 4'(b);
        sp[i] = 8'(p);
      end
    end
  endtask

  // Reference statistics from plain integer arithmetic over the sample set.
  int m_cnt, m_err, m_sabs, m_serr, m_max;

  task automatic model_run(input int n, input int sum_w);
    longint lim, modv, serr, sabs;
    lim  = (longint'(1) << sum_w) - 1;
    modv = longint'(1) << (sum_w + 1);
    serr = 0;
    sabs = 0;
    m_cnt = 0; m_err = 0; m_max = 0;
    for (int i = 0; i < n; i++) begin
      int d, ad;
      d  = int'(sp[i]) - int'(sa[i]) * int'(sb[i]);
      ad = (d < 0) ? -d : d;
      m_cnt++;
      if (d != 0) m_err++;
      sabs = sabs + ad;
      if (sabs > lim) sabs = lim;
      serr = serr + d;
      if (ad > m_max) m_max = ad;
    end
    serr = ((serr % modv) + modv) % modv;
    if (serr >= modv / 2) serr = serr - modv;
    m_sabs = int'(sabs);
    m_serr = int'(serr);
  endtask

  task automatic cmp_stats(input string tag, input int c, input int e, input int sabs,
                           input int serr, input int mx);
    check({tag, "_sample_cnt"}, sample_cnt, c);
    check({tag, "_err_cnt"}, err_cnt, e);
    check({tag, "_sum_abs_err"}, sum_abs_err, sabs);
    check({tag, "_sum_err"}, $signed(sum_err), serr);
    check({tag, "_max_abs_err"}, max_abs_err, mx);
  endtask

  // Drives one run over sa/sb/sp with random valid gaps and a stray start
  // pulse mid-run. With abort_at >= 0 it stops feeding after that many
  // transfers and leaves the DUT mid-run.
  task automatic do_run(input string tag, input int gap_pct, input int abort_at);
    int  idx, guard, lat;
    bit  fired, mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_low_after_start"}, done, 0);
    check({tag, "_busy_after_start"}, busy, 1);
    idx = 0; guard = 0; mid = 1'b0;
    while (idx < 256 && guard < 4000) begin
      if (idx == abort_at) break;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_a = sa[idx];
      in_b = sb[idx];
      in_p = sp[idx];
      if (idx == 128 && !mid) begin
        start = 1'b1;
        mid = 1'b1;
      end
      fired = in_valid && in_ready;
      tick();
      start = 1'b0;
      if (fired) idx++;
      guard++;
    end
    if (abort_at >= 0) begin
      in_valid = 1'b0;
      return;
    end
    check({tag, "_feed_timeout"}, (guard >= 4000) ? 1 : 0, 0);
    // Keep offering a bogus sample through DRAIN and DONE.
    in_valid = 1'b1;
    in_a = 4'd15; in_b = 4'd15; in_p = 8'd0;
    check({tag, "_ready_drop"}, in_ready, 0);
    lat = 0;
    while (!done && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_done_latency"}, lat, 3);
    repeat (4) tick();
    check({tag, "_ready_in_done"}, in_ready, 0);
    in_valid = 1'b0;
  endtask

  typedef struct {
    int mode;
    int gap;
    bit use_model;
    int c, e, sabs, serr, mx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // mode: 0 exact, 1 A==3 -> +1, 2 -2 bias where A*B>=2, 3 random P, 4 (0,0)->255
    vecs[0] = '{0, 0,  1'b0, 256, 0,   0,   0,    0};
    vecs[1] = '{1, 30, 1'b0, 256, 16,  16,  16,   1};
    vecs[2] = '{2, 0,  1'b0, 256, 224, 448, -448, 2};
    vecs[3] = '{4, 50, 1'b0, 256, 1,   255, 255,  255};
    vecs[4] = '{3, 40, 1'b1, 0,   0,   0,   0,    0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_p = '0;
    s_start = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_p = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 0);
    cmp_stats("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      build(vecs[i].mode);
      do_run(tag, vecs[i].gap, -1);
      if (vecs[i].use_model) begin
        model_run(256, 16);
        cmp_stats(tag, m_cnt, m_err, m_sabs, m_serr, m_max);
      end else begin
        cmp_stats(tag, vecs[i].c, vecs[i].e, vecs[i].sabs, vecs[i].serr, vecs[i].mx);
      end
    end

    // Reset in the middle of a run discards it; a fresh run matches a clean one.
    build(1);
    do_run("abort", 0, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_in_ready", in_ready, 0);
    cmp_stats("abort", 0, 0, 0, 0, 0);
    do_run("after_abort", 20, -1);
    cmp_stats("after_abort", 256, 16, 16, 16, 1);

    // Narrow accumulator: four samples with |diff| = 100.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    w = 0;
    for (int k = 0; k < 4 && w < 100; ) begin
      bit f;
      s_valid = 1'b1; s_a = 4'd0; s_b = 4'd0; s_p = 8'd100;
      f = s_valid && s_ready;
      tick();
      if (f) k++;
      w++;
    end
    s_valid = 1'b0;
    w = 0;
    while (!s_done && w < 50) begin
      tick();
      w++;
    end
    check("sat_done_seen", s_done, 1);
    check("sat_sample_cnt", s_sample_cnt, 4);
    check("sat_err_cnt", s_err_cnt, 4);
    check("sat_sum_abs_err", s_sum_abs_err, 255);
    check("sat_sum_err", $signed(s_sum_err), -112);
    check("sat_max_abs_err", s_max_abs_err, 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
